comparador_mayor: RTL and testbench
===================================

# comparador_mayor

Registered magnitude comparator: raises `Out` when operand `A` is strictly greater than operand `B`. It is a compare primitive in the floating-point datapath, used by the natural-logarithm unit for exponent and mantissa magnitude decisions. Combinational compare logic feeds a single output register, so the result is available one clock after the operands are sampled.

## Interface
- `W`, default 8: operand width in bits, must be ≥ 2.
- `SIGNED`, default 0:
  - 0 compares `A` and `B` as unsigned integers.
  - 1 compares them as two's-complement integers.
- `CLK` input, 1 bit: the single clock; all state updates on its rising edge.
- `RST_N` input, 1 bit: reset, asynchronous, active-low.
- `A` input, W bits: first operand.
- `B` input, W bits: second operand.
- `Out` output, 1 bit, registered: 1 when A > B, else 0.

## Operation
- Combinational result `gt` is 1 iff A > B under the selected interpretation. Strict comparison: A == B gives 0.
- Unsigned mode: plain magnitude compare over all W bits.
- Signed mode: invert the MSB of both operands, then do the unsigned compare. This is equivalent to a two's-complement compare.
- Compare structure is a tree, not a W-bit subtractor:
  - Each leaf handles a 2-bit slice of A and B. It produces a greater flag `g` and an equal flag `e` for that slice.
  - Combine stage: (g_hi, e_hi) and (g_lo, e_lo) give g = g_hi | (e_hi & g_lo) and e = e_hi & e_lo.
  - Levels repeat until one (g, e) pair remains. `gt` is that final `g`.
  - Odd W: pad the LSB end with one bit set equal in A and B (0 and 0).
- Register update: `Out` takes `gt` on every rising `CLK` edge while `RST_N` is high. There is no enable and no handshake, so each edge samples new operands.
- X/Z on the inputs is not filtered; the bench always drives known values.

## Timing
- Reset:
  - `RST_N` low forces `Out` = 0 immediately, with no clock needed, and holds it at 0 while low.
  - When reset is released, the first rising edge with `RST_N` high loads `gt` from the current A and B.
- Latency: exactly 1 cycle. Operands present before rising edge k appear on `Out` after edge k.
- Throughput: one compare per cycle.
- Operand changes between edges have no effect on `Out` until the next edge.
- Reset asserted mid-operation: `Out` drops to 0 asynchronously. The compare result in flight is discarded.
- Boundary pairs give these results:
  - Unsigned: A=all-ones, B=0 gives 1. A=0, B=all-ones gives 0.
  - Signed: A = 0x7F..., B = 0x80... gives 1.

## Structure
- Shared package `fpu_cmp_pkg`:
  - Constant `CMP_W_DEFAULT` = 8.
  - Leaf slice width constant = 2.
  - Typedef `cmp_ge_t`, a struct holding `g` and `e`.
- Sub-module `cmp_gt_cell` is the 2-bit leaf: inputs a[1:0] and b[1:0], outputs g and e.
- The top generates the leaf array and the combine levels with generate loops. The output register lives in the top.

## Test plan
- W=8, SIGNED=0, A=0x80, B=0x7F, clock period 10 ns:
  - `Out` is 0 before the first edge.
  - `Out` is 1 after the first rising edge.
- Same instance with SIGNED=1, A=0x80, B=0x7F: `Out` = 0 after the edge (-128 < 127).
- Equality and extremes, unsigned:
  - A=B=0x55 gives 0.
  - A=0xFF, B=0xFE gives 1.
  - A=0x00, B=0xFF gives 0.
  - A=0xFF, B=0x00 gives 1.
  - Each result appears exactly one cycle after its operands.
- Latency check: change A/B mid-cycle. `Out` must not change until the next rising edge.
- Reset mid-operation:
  - With `Out`=1, pull `RST_N` low between edges. `Out` must go to 0 immediately and stay 0 across edges while reset is low.
  - Release reset. `Out` must reflect A>B after the next edge.
- Exhaustive sweep: all 65 536 (A, B) pairs for W=8 in both modes, checked against a reference model delayed by one cycle.

Source files
------------

// File: rtl/fpu_cmp_pkg.sv
// Shared types and constants for the floating-point compare primitives.
// Leaf slice width and the (greater, equal) pair that flows up the compare tree.
package fpu_cmp_pkg;

    localparam int CMP_W_DEFAULT = 8;
    localparam int CMP_LEAF_W    = 2;

    typedef struct packed {
        logic g;
        logic e;
    } cmp_ge_t;

    // hi slice dominates; lo only matters when hi slices are equal
    function automatic cmp_ge_t cmp_combine(input cmp_ge_t hi, input cmp_ge_t lo);
        cmp_ge_t r;
        r.g = hi.g | (hi.e & lo.g);
        r.e = hi.e & lo.e;
        return r;
    endfunction

endpackage

// File: rtl/cmp_gt_cell.sv
// 2-bit magnitude compare leaf: greater and equal flags for one operand slice.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module cmp_gt_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       e
);

    assign g = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
    assign e = (a == b);

endmodule

// File: rtl/comparador_mayor.sv
// Registered A > B comparator (unsigned or two's complement) built as a g/e tree.
// Latency: 1 cycle from operand sampling to Out.
// Backpressure: none, a new compare is sampled on every rising edge.
module comparador_mayor
    import fpu_cmp_pkg::*;
#(
    parameter int W      = CMP_W_DEFAULT,
    parameter bit SIGNED = 1'b0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         Out
);

    localparam int WP    = W + (W % CMP_LEAF_W);
    localparam int NLEAF = WP / CMP_LEAF_W;
    localparam int DEPTH = $clog2(NLEAF);
    localparam int NL    = 1 << DEPTH;

    // Flipping the sign bit maps two's complement order onto unsigned order
    localparam logic [W-1:0] MSB_FLIP = {SIGNED, {(W-1){1'b0}}};

    logic [W-1:0]  a_m, b_m;
    logic [WP-1:0] a_p, b_p;
    logic          gt;
    cmp_ge_t       lv [DEPTH+1][NL];

    assign a_m = A ^ MSB_FLIP;
    assign b_m = B ^ MSB_FLIP;

    generate
        if (WP != W) begin : g_pad_odd
            assign a_p = {a_m, 1'b0};
            assign b_p = {b_m, 1'b0};
        end else begin : g_even
            assign a_p = a_m;
            assign b_p = b_m;
        end

        // Leaves beyond NLEAF are neutral (g=0, e=1) so the tree can be a full power of two
        for (genvar i = 0; i < NL; i++) begin : g_leaf
            if (i < NLEAF) begin : g_cell
                logic lg, le;
                cmp_gt_cell u_cell (
                    .a (a_p[CMP_LEAF_W*i +: CMP_LEAF_W]),
                    .b (b_p[CMP_LEAF_W*i +: CMP_LEAF_W]),
                    .g (lg),
                    .e (le)
                );
                assign lv[0][i] = '{g: lg, e: le};
            end else begin : g_neutral
                assign lv[0][i] = '{g: 1'b0, e: 1'b1};
            end
        end

        for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
            for (genvar j = 0; j < NL; j++) begin : g_node
                if (j < (NL >> l)) begin : g_comb
                    assign lv[l][j] = cmp_combine(lv[l-1][2*j+1], lv[l-1][2*j]);
                end else begin : g_idle
                    assign lv[l][j] = '{g: 1'b0, e: 1'b1};
                end
            end
        end
    endgenerate

    assign gt = lv[DEPTH][0].g;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Out <= 1'b0;
        end else begin
            Out <= gt;
        end
    end

endmodule

// File: tb/tb_comparador_mayor.sv
// Scoreboarded bench: unsigned and signed instances share operands; a monitor
// pops expected results one edge after each vector is driven.
module tb_comparador_mayor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       gu;
        logic       gs;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic       out_u, out_s;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    comparador_mayor #(.W(8), .SIGNED(1'b0)) dut_u (
        .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .Out(out_u)
    );
    comparador_mayor #(.W(8), .SIGNED(1'b1)) dut_s (
        .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .Out(out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // drive on the falling edge, result expected after the next rising edge
    task automatic apply(input logic [7:0] va, input logic [7:0] vb,
                         input logic eu, input logic es);
        exp_t e;
        @(negedge clk);
        a = va;
        b = vb;
        e.a = va; e.b = vb; e.gu = eu; e.gs = es;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("unsigned %02h>%02h", e.a, e.b), out_u, e.gu);
            chk($sformatf("signed %02h>%02h", e.a, e.b), out_s, e.gs);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] da [8];
        logic [7:0] db [8];
        logic       du [8];
        logic       ds [8];
        exp_t       e0;

        da = '{8'h80, 8'h55, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'h80};
        db = '{8'h7F, 8'h55, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h81};
        du = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        ds = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

        rst_n = 1'b0;
        a = 8'h80;
        b = 8'h7F;
        #1;
        chk("reset_u", out_u, 1'b0);
        chk("reset_s", out_s, 1'b0);
        #2;
        rst_n = 1'b1;
        e0.a = 8'h80; e0.b = 8'h7F; e0.gu = 1'b1; e0.gs = 1'b0;
        q.push_back(e0);

        for (int i = 0; i < 8; i++) apply(da[i], db[i], du[i], ds[i]);

        // operand change between edges must not reach Out early
        apply(8'h20, 8'h10, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        a = 8'h10;
        b = 8'h20;
        #1;
        chk("hold_mid_cycle_u", out_u, 1'b1);
        chk("hold_mid_cycle_s", out_s, 1'b1);
        apply(8'h10, 8'h20, 1'b0, 1'b0);

        // asynchronous reset with Out high
        apply(8'h70, 8'h10, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_u", out_u, 1'b0);
        chk("async_reset_s", out_s, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold_u", out_u, 1'b0);
            chk("reset_hold_s", out_s, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h70;
        b = 8'h10;
        e0.a = 8'h70; e0.b = 8'h10; e0.gu = 1'b1; e0.gs = 1'b1;
        q.push_back(e0);

        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                logic [7:0] va, vb;
                va = 8'(i);
                vb = 8'(j);
                apply(va, vb, va > vb, $signed(va) > $signed(vb));
            end
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
